// File: rtl/fade_ramp.sv
// fade_ramp: brightness sequencer feeding an LED PWM stage.
//
// Produces a triangle-with-hold duty profile (ramp up, hold full, ramp down,
// hold off, repeat). Duty, state and counters change only on the last clock
// of a PWM period, so new values appear together with period_start.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   enable       in   1 = ramp advances, 0 = ramp frozen (period counter still runs)
//   duty         out  current duty, 0..PWM_INTERVAL (registered)
//   period_start out  high while period_cnt == 0 and not in reset (combinational)
//   state        out  UP=0, HOLD_HI=1, DOWN=2, HOLD_LO=3 (registered)
//   pwm_out      out  registered (period_cnt < duty); present only when
//                     FADE_RAMP_PWM_OUT_EN is defined
//
// Build option: define FADE_RAMP_PWM_OUT_EN to add the built-in PWM comparator.
module fade_ramp #(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned DUTY_W       = 11,
    parameter int unsigned STEP         = 10,
    parameter int unsigned STEP_PERIODS = 10,
    parameter int unsigned HOLD_STEPS   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [DUTY_W-1:0] duty,
    output logic              period_start,
`ifdef FADE_RAMP_PWM_OUT_EN
    output logic              pwm_out,
`endif
    output logic [1:0]        state
);

    localparam int unsigned PCNT_W = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam int unsigned SCNT_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int unsigned HCNT_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PWM_INTERVAL - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STEP_PERIODS - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'((HOLD_STEPS == 0) ? 0 : HOLD_STEPS - 1);

    // One extra bit so duty + STEP cannot wrap before the clamp.
    localparam logic [DUTY_W:0]   FULL_X    = (DUTY_W + 1)'(PWM_INTERVAL);
    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] DUTY_STEP = DUTY_W'(STEP);

    typedef enum logic [1:0] {
        StUp     = 2'd0,
        StHoldHi = 2'd1,
        StDown   = 2'd2,
        StHoldLo = 2'd3
    } state_e;

    logic [PCNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [SCNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    state_e            state_q, state_d;

    logic              period_tick;
    logic              step_evt;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   up_nxt;
    logic [DUTY_W-1:0] dn_nxt;

    assign period_tick = (period_cnt_q == PCNT_LAST) && enable;
    assign step_evt    = period_tick && (step_cnt_q == SCNT_LAST);

    always_comb begin
        period_cnt_d = (period_cnt_q == PCNT_LAST) ? '0 : period_cnt_q + 1'b1;
        step_cnt_d   = step_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        duty_d       = duty_q;
        state_d      = state_q;

        up_sum = {1'b0, duty_q} + STEP_X;
        up_nxt = (up_sum > FULL_X) ? FULL_X : up_sum;
        dn_nxt = ({1'b0, duty_q} <= STEP_X) ? '0 : duty_q - DUTY_STEP;

        if (period_tick) begin
            step_cnt_d = step_evt ? '0 : step_cnt_q + 1'b1;
        end

        if (step_evt) begin
            unique case (state_q)
                StUp: begin
                    duty_d = up_nxt[DUTY_W-1:0];
                    if (up_nxt == FULL_X) begin
                        state_d = (HOLD_STEPS == 0) ? StDown : StHoldHi;
                    end
                end
                StHoldHi: begin
                    if (hold_cnt_q == HCNT_LAST) begin
                        hold_cnt_d = '0;
                        state_d    = StDown;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                StDown: begin
                    duty_d = dn_nxt;
                    if (dn_nxt == '0) begin
                        state_d = (HOLD_STEPS == 0) ? StUp : StHoldLo;
                    end
                end
                StHoldLo: begin
                    if (hold_cnt_q == HCNT_LAST) begin
                        hold_cnt_d = '0;
                        state_d    = StUp;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt_q <= '0;
            step_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            duty_q       <= '0;
            state_q      <= StUp;
        end else begin
            period_cnt_q <= period_cnt_d;
            step_cnt_q   <= step_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            duty_q       <= duty_d;
            state_q      <= state_d;
        end
    end

    assign duty         = duty_q;
    assign state        = state_q;
    assign period_start = rst_n && (period_cnt_q == '0);

`ifdef FADE_RAMP_PWM_OUT_EN
    logic pwm_out_q, pwm_out_d;

    // Compare in a common width; duty == PWM_INTERVAL is therefore always high.
    always_comb begin
        pwm_out_d = (32'(period_cnt_q) < 32'(duty_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_out_q <= 1'b0;
        end else begin
            pwm_out_q <= pwm_out_d;
        end
    end

    assign pwm_out = pwm_out_q;
`endif

endmodule

// File: tb/tb_fade_ramp.sv
// Directed bench for fade_ramp. Three instances with PWM_INTERVAL=10,
// STEP_PERIODS=2: A (STEP=5, HOLD_STEPS=1), B (STEP=4, HOLD_STEPS=1),
// C (STEP=4, HOLD_STEPS=0). Cycle 0 is the first cycle after reset release;
// inputs are driven and outputs sampled just after the falling edge.
`timescale 1ns/1ps
module tb_fade_ramp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, en_a;
    logic [4:0] duty_a;
    logic       ps_a;
    logic [1:0] st_a;

    logic       rst_bc_n, en_bc;
    logic [4:0] duty_b, duty_c;
    logic       ps_b, ps_c;
    logic [1:0] st_b, st_c;

`ifdef FADE_RAMP_PWM_OUT_EN
    logic pwm_a, pwm_b, pwm_c;
`endif

    fade_ramp #(.PWM_INTERVAL(10), .DUTY_W(5), .STEP(5), .STEP_PERIODS(2), .HOLD_STEPS(1)) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_a_n),
        .enable       (en_a),
        .duty         (duty_a),
        .period_start (ps_a),
`ifdef FADE_RAMP_PWM_OUT_EN
        .pwm_out      (pwm_a),
`endif
        .state        (st_a)
    );

    fade_ramp #(.PWM_INTERVAL(10), .DUTY_W(5), .STEP(4), .STEP_PERIODS(2), .HOLD_STEPS(1)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_bc_n),
        .enable       (en_bc),
        .duty         (duty_b),
        .period_start (ps_b),
`ifdef FADE_RAMP_PWM_OUT_EN
        .pwm_out      (pwm_b),
`endif
        .state        (st_b)
    );

    fade_ramp #(.PWM_INTERVAL(10), .DUTY_W(5), .STEP(4), .STEP_PERIODS(2), .HOLD_STEPS(0)) u_dut_c (
        .clk          (clk),
        .rst_n        (rst_bc_n),
        .enable       (en_bc),
        .duty         (duty_c),
        .period_start (ps_c),
`ifdef FADE_RAMP_PWM_OUT_EN
        .pwm_out      (pwm_c),
`endif
        .state        (st_c)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_a    = 0;
    int cyc_b    = 0;
    bit done_bc  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic goto_a(input int n);
        while (cyc_a < n) begin
            @(negedge clk);
            cyc_a++;
        end
        #1;
    endtask

    task automatic goto_b(input int n);
        while (cyc_b < n) begin
            @(negedge clk);
            cyc_b++;
        end
        #1;
    endtask

    // Full reset of instance A; returns in cycle 0 just after release.
    task automatic restart_a();
        rst_a_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        cyc_a   = 0;
        #1;
    endtask

    // Instance A: ramp, pwm, mid-ramp reset, restarted ramp, enable freeze.
    initial begin
        rst_a_n = 1'b0;
        en_a    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("a_rst_ps", ps_a, 0);
        check_eq("a_rst_duty", duty_a, 0);
        check_eq("a_rst_state", st_a, 0);
`ifdef FADE_RAMP_PWM_OUT_EN
        check_eq("a_rst_pwm", pwm_a, 0);
`endif
        rst_a_n = 1'b1;
        cyc_a   = 0;
        #1;
        check_eq("a_c0_ps", ps_a, 1);
        check_eq("a_c0_duty", duty_a, 0);
        goto_a(9);   check_eq("a_c9_ps", ps_a, 0);
        goto_a(10);  check_eq("a_c10_ps", ps_a, 1);
        goto_a(19);  check_eq("a_c19_duty", duty_a, 0);
        goto_a(20);  check_eq("a_c20_duty", duty_a, 5);
                     check_eq("a_c20_state", st_a, 0);
`ifdef FADE_RAMP_PWM_OUT_EN
        for (int c = 20; c < 40; c++) begin
            goto_a(c);
            check_eq("a_pwm_d5", pwm_a, ((c % 10) >= 1 && (c % 10) <= 5) ? 1 : 0);
        end
`endif
        goto_a(40);  check_eq("a_c40_duty", duty_a, 10);
                     check_eq("a_c40_state", st_a, 1);
        goto_a(59);  check_eq("a_c59_state", st_a, 1);
        goto_a(60);  check_eq("a_c60_state", st_a, 2);
                     check_eq("a_c60_duty", duty_a, 10);
        goto_a(80);  check_eq("a_c80_duty", duty_a, 5);
                     check_eq("a_c80_state", st_a, 2);

        // One-cycle reset in the middle of DOWN.
        goto_a(85);
        rst_a_n = 1'b0;
        #1;
        check_eq("a_mid_rst_ps", ps_a, 0);
        check_eq("a_mid_rst_hold_duty", duty_a, 5);
        goto_a(86);
        check_eq("a_mid_rst_duty", duty_a, 0);
        check_eq("a_mid_rst_state", st_a, 0);
        check_eq("a_mid_rst_ps_gated", ps_a, 0);
`ifdef FADE_RAMP_PWM_OUT_EN
        check_eq("a_mid_rst_pwm", pwm_a, 0);
`endif
        rst_a_n = 1'b1;
        cyc_a   = 0;
        #1;
        check_eq("b0_ps", ps_a, 1);
        goto_a(19);  check_eq("b19_duty", duty_a, 0);
        goto_a(20);  check_eq("b20_duty", duty_a, 5);
        goto_a(40);  check_eq("b40_duty", duty_a, 10);
                     check_eq("b40_state", st_a, 1);
        goto_a(60);  check_eq("b60_state", st_a, 2);
        goto_a(80);  check_eq("b80_duty", duty_a, 5);
        goto_a(100); check_eq("b100_duty", duty_a, 0);
                     check_eq("b100_state", st_a, 3);
        goto_a(120); check_eq("b120_state", st_a, 0);
                     check_eq("b120_duty", duty_a, 0);
        goto_a(139); check_eq("b139_duty", duty_a, 0);
        goto_a(140); check_eq("b140_duty", duty_a, 5);

        // Enable freeze from cycle 25 to cycle 65.
        restart_a();
        goto_a(20);  check_eq("e20_duty", duty_a, 5);
        goto_a(25);  en_a = 1'b0;
        for (int c = 30; c <= 60; c += 10) begin
            goto_a(c);
            check_eq("e_frz_ps", ps_a, 1);
            check_eq("e_frz_duty", duty_a, 5);
            check_eq("e_frz_state", st_a, 0);
        end
        goto_a(61);  check_eq("e61_ps", ps_a, 0);
        goto_a(65);  en_a = 1'b1;
        goto_a(70);  check_eq("e70_duty", duty_a, 5);
        goto_a(79);  check_eq("e79_duty", duty_a, 5);
        goto_a(80);  check_eq("e80_duty", duty_a, 10);
                     check_eq("e80_state", st_a, 1);

        for (int i = 0; i < 1000 && !done_bc; i++) @(negedge clk);
        check_eq("bc_done", done_bc, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Instances B and C: clamping at both ends, with and without hold.
    initial begin
        rst_bc_n = 1'b0;
        en_bc    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst_bc_n = 1'b1;
        cyc_b    = 0;
        #1;
        goto_b(19);  check_eq("b_c19_duty", duty_b, 0);
        goto_b(20);  check_eq("b_c20_duty", duty_b, 4);
                     check_eq("c_c20_duty", duty_c, 4);
        goto_b(40);  check_eq("b_c40_duty", duty_b, 8);
        goto_b(60);  check_eq("b_c60_duty", duty_b, 10);
                     check_eq("b_c60_state", st_b, 1);
                     check_eq("c_c60_duty", duty_c, 10);
                     check_eq("c_c60_state", st_c, 2);
        goto_b(80);  check_eq("b_c80_duty", duty_b, 10);
                     check_eq("b_c80_state", st_b, 2);
                     check_eq("c_c80_duty", duty_c, 6);
        goto_b(100); check_eq("b_c100_duty", duty_b, 6);
                     check_eq("c_c100_duty", duty_c, 2);
        goto_b(120); check_eq("b_c120_duty", duty_b, 2);
                     check_eq("c_c120_duty", duty_c, 0);
                     check_eq("c_c120_state", st_c, 0);
        goto_b(140); check_eq("b_c140_duty", duty_b, 0);
                     check_eq("b_c140_state", st_b, 3);
                     check_eq("c_c140_duty", duty_c, 4);
        goto_b(160); check_eq("b_c160_state", st_b, 0);
                     check_eq("b_c160_duty", duty_b, 0);
        goto_b(180); check_eq("b_c180_duty", duty_b, 4);
        done_bc = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
